// File: rtl/hs_spi_arb_pkg.sv
// Shared types and helpers for the HS-SPI AXI4-Lite request arbiter.
package hs_spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    WAIT_B,
    WAIT_R,
    RESP
  } state_t;

  localparam logic [1:0] AXI_OKAY = 2'b00;

  // Index of the first set request at or after ptr, wrapping at n (n <= 8).
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input int unsigned n);
    logic       found;
    logic [3:0] idx;
    rr_pick = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= 4'(n)) idx = idx - 4'(n);
      if ((i < n) && !found && req[idx[2:0]]) begin
        found   = 1'b1;
        rr_pick = idx[2:0];
      end
    end
  endfunction

endpackage

// File: rtl/hs_spi_rr_pick.sv
// Combinational round-robin chooser: first requester at/after ptr wins.
module hs_spi_rr_pick
  import hs_spi_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] gnt_idx,
  output logic                    any
);

  localparam int unsigned IW = $clog2(NREQ);

  assign gnt_idx = IW'(rr_pick(8'(req), 3'(ptr), NREQ));
  assign any     = |req;

endmodule

// File: rtl/hs_spi_axi_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite slave (HS-SPI bridge) between
// NREQ single-beat request ports, one outstanding transaction at a time.
// Optional macro HS_SPI_ARB_IDLE_WAIT_EN: grant only while spi_idle is high.
module hs_spi_axi_arbiter
  import hs_spi_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 10,
  parameter int unsigned DW   = 32
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 rsp_err,
  output logic [AW-1:0]        m_axi_awaddr,
  output logic [2:0]           m_axi_awprot,
  output logic                 m_axi_awvalid,
  input  logic                 m_axi_awready,
  output logic [DW-1:0]        m_axi_wdata,
  output logic [DW/8-1:0]      m_axi_wstrb,
  output logic                 m_axi_wvalid,
  input  logic                 m_axi_wready,
  input  logic [1:0]           m_axi_bresp,
  input  logic                 m_axi_bvalid,
  output logic                 m_axi_bready,
  output logic [AW-1:0]        m_axi_araddr,
  output logic [2:0]           m_axi_arprot,
  output logic                 m_axi_arvalid,
  input  logic                 m_axi_arready,
  input  logic [DW-1:0]        m_axi_rdata,
  input  logic [1:0]           m_axi_rresp,
  input  logic                 m_axi_rvalid,
  output logic                 m_axi_rready,
  input  logic                 spi_idle,
  output logic                 busy
);

  localparam int unsigned IW = $clog2(NREQ);

  state_t         state;
  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  gidx;
  logic [IW-1:0]  gnt_q;
  logic [AW-1:0]  addr_q;
  logic [DW-1:0]  wdata_q;
  logic           any_req;
  logic           can_grant;
  logic           grant;

  hs_spi_rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt_idx (gidx),
    .any     (any_req)
  );

`ifdef HS_SPI_ARB_IDLE_WAIT_EN
  assign can_grant = spi_idle;
`else
  logic unused_spi_idle;
  assign unused_spi_idle = spi_idle;
  assign can_grant       = 1'b1;
`endif

  // aresetn gates the grant so req_ready stays low throughout reset
  assign grant = (state == IDLE) && any_req && can_grant && aresetn;
  assign busy  = (state != IDLE);

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = '1;
  assign m_axi_awprot = '0;
  assign m_axi_arprot = '0;

  // One-hot acceptance strobe for the requester chosen this cycle
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gidx] = 1'b1;
  end

  // Transaction sequencer: grant, AXI handshakes, one-cycle response
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      gnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= '0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            gnt_q   <= gidx;
            addr_q  <= req_addr[gidx*AW +: AW];
            wdata_q <= req_wdata[gidx*DW +: DW];
            rr_ptr  <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            if (req_write[gidx]) begin
              state         <= WR;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
            end else begin
              state         <= RD;
              m_axi_arvalid <= 1'b1;
            end
          end
        end
        WR: begin
          // AW and W complete independently; a valid already dropped counts as done
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            state        <= WAIT_B;
            m_axi_bready <= 1'b1;
          end
        end
        RD: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= WAIT_R;
          end
        end
        WAIT_B: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_valid    <= NREQ'(1) << gnt_q;
            rsp_rdata    <= '0;
            rsp_err      <= (m_axi_bresp != AXI_OKAY);
            state        <= RESP;
          end
        end
        WAIT_R: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_valid    <= NREQ'(1) << gnt_q;
            rsp_rdata    <= m_axi_rdata;
            rsp_err      <= (m_axi_rresp != AXI_OKAY);
            state        <= RESP;
          end
        end
        RESP: begin
          rsp_valid <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
